// File: rtl/mouse_cmd_scheduler.sv
// mouse_cmd_scheduler: PS/2 mouse packet assembly and safe runtime command scheduling between packets
module mouse_cmd_scheduler #(
  parameter int         ACK_TIMEOUT = 2000000,
  parameter logic [7:0] ACK_BYTE    = 8'hFA,
  parameter logic [7:0] CMD_DISABLE = 8'hF5,
  parameter logic [7:0] CMD_ENABLE  = 8'hF4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       STREAM_EN,
  output logic       OWN,
  input  logic       CFG_REQ,
  input  logic [7:0] CFG_CMD,
  input  logic       CFG_HAS_ARG,
  input  logic [7:0] CFG_ARG,
  output logic       CFG_BUSY,
  output logic       CFG_DONE,
  output logic       CFG_ERR,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] PKT_STATUS,
  output logic [7:0] PKT_DX,
  output logic [7:0] PKT_DY,
  output logic       PKT_VALID
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, STREAM, TX, TXW, ACKW} state_t;
  typedef enum logic [1:0] {DIS, CMD, ARG, EN} stage_t;
  state_t state_q, state_d;
  stage_t stage_q, stage_d;
  logic [1:0] idx_q, idx_d, disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, has_arg_q, has_arg_d;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d, stat_q, stat_d, dx_q, dx_d;
  logic [7:0] pkt_status_q, pkt_status_d, pkt_dx_q, pkt_dx_d, pkt_dy_q, pkt_dy_d;
  logic pkt_valid_q, pkt_valid_d, done_q, done_d, cerr_q, cerr_d;
  logic busy, good, ack;
  assign busy = state_q inside {TX, TXW, ACKW};
  assign good = BYTE_READY && BYTE_ERROR_CODE == 2'd0;
  assign ack = good && BYTE_READ == ACK_BYTE;
  assign OWN = state_q != IDLE;
  assign READ_ENABLE = state_q == STREAM || state_q == ACKW;
  assign SEND_BYTE = state_q == TX;
  assign BYTE_TO_SEND = state_q != TX ? 8'h00 :
                        stage_q == DIS ? CMD_DISABLE :
                        stage_q == CMD ? cmd_q :
                        stage_q == ARG ? arg_q : CMD_ENABLE;
  assign CFG_BUSY = busy;
  assign CFG_DONE = done_q;
  assign CFG_ERR = cerr_q;
  assign PKT_STATUS = pkt_status_q;
  assign PKT_DX = pkt_dx_q;
  assign PKT_DY = pkt_dy_q;
  assign PKT_VALID = pkt_valid_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      stage_q <= DIS;
      idx_q <= '0;
      disc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      has_arg_q <= 1'b0;
      cmd_q <= '0;
      arg_q <= '0;
      stat_q <= '0;
      dx_q <= '0;
      pkt_status_q <= '0;
      pkt_dx_q <= '0;
      pkt_dy_q <= '0;
      pkt_valid_q <= 1'b0;
      done_q <= 1'b0;
      cerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      idx_q <= idx_d;
      disc_q <= disc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      has_arg_q <= has_arg_d;
      cmd_q <= cmd_d;
      arg_q <= arg_d;
      stat_q <= stat_d;
      dx_q <= dx_d;
      pkt_status_q <= pkt_status_d;
      pkt_dx_q <= pkt_dx_d;
      pkt_dy_q <= pkt_dy_d;
      pkt_valid_q <= pkt_valid_d;
      done_q <= done_d;
      cerr_q <= cerr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    idx_d = idx_q;
    disc_d = disc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    has_arg_d = has_arg_q;
    cmd_d = cmd_q;
    arg_d = arg_q;
    stat_d = stat_q;
    dx_d = dx_q;
    pkt_status_d = pkt_status_q;
    pkt_dx_d = pkt_dx_q;
    pkt_dy_d = pkt_dy_q;
    pkt_valid_d = 1'b0;
    done_d = 1'b0;
    cerr_d = 1'b0;
    if (!STREAM_EN) begin
      state_d = IDLE;
      idx_d = '0;
      cerr_d = busy;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = STREAM;
          idx_d = '0;
        end
        STREAM: begin
          if (BYTE_READY) begin
            if (!good) idx_d = '0;
            else if (idx_q == 2'd0) begin
              stat_d = BYTE_READ;
              idx_d = BYTE_READ[3] ? 2'd1 : 2'd0;
            end else if (idx_q == 2'd1) begin
              dx_d = BYTE_READ;
              idx_d = 2'd2;
            end else begin
              pkt_status_d = stat_q;
              pkt_dx_d = dx_q;
              pkt_dy_d = BYTE_READ;
              pkt_valid_d = 1'b1;
              idx_d = '0;
            end
          end else if (idx_q == 2'd0 && CFG_REQ) begin
            cmd_d = CFG_CMD;
            arg_d = CFG_ARG;
            has_arg_d = CFG_HAS_ARG;
            stage_d = DIS;
            err_d = 1'b0;
            state_d = TX;
          end
        end
        TX: state_d = TXW;
        TXW: begin
          if (BYTE_SENT) begin
            cnt_d = '0;
            disc_d = '0;
            state_d = ACKW;
          end
        end
        ACKW: begin
          cnt_d = cnt_q + 1'b1;
          if (ack) begin
            state_d = stage_q == EN ? STREAM : TX;
            stage_d = stage_q == DIS ? CMD :
                      stage_q == CMD ? (has_arg_q ? ARG : EN) : EN;
            if (stage_q == EN) begin
              idx_d = '0;
              done_d = !err_q;
              cerr_d = err_q;
              err_d = 1'b0;
            end
          end else if (stage_q == DIS && good && disc_q != 2'd3) begin
            disc_d = disc_q + 1'b1;
          end else if (BYTE_READY || cnt_q == CW'(ACK_TIMEOUT)) begin
            state_d = stage_q == EN ? STREAM : TX;
            stage_d = EN;
            idx_d = '0;
            cerr_d = stage_q == EN;
            err_d = stage_q != EN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mouse_cmd_scheduler.sv
// tb_mouse_cmd_scheduler: directed self-checking bench for mouse_cmd_scheduler
module tb_mouse_cmd_scheduler;
  logic CLK = 1'b0, RESET = 1'b1, STREAM_EN = 1'b0;
  logic CFG_REQ = 1'b0, CFG_HAS_ARG = 1'b0, BYTE_SENT = 1'b0, BYTE_READY = 1'b0;
  logic [7:0] CFG_CMD = '0, CFG_ARG = '0, BYTE_READ = '0;
  logic [1:0] BYTE_ERROR_CODE = '0;
  logic OWN, CFG_BUSY, CFG_DONE, CFG_ERR, SEND_BYTE, READ_ENABLE, PKT_VALID;
  logic [7:0] BYTE_TO_SEND, PKT_STATUS, PKT_DX, PKT_DY;
  int tests = 0, fails = 0;
  mouse_cmd_scheduler #(.ACK_TIMEOUT(20)) dut (
    .CLK(CLK), .RESET(RESET), .STREAM_EN(STREAM_EN), .OWN(OWN),
    .CFG_REQ(CFG_REQ), .CFG_CMD(CFG_CMD), .CFG_HAS_ARG(CFG_HAS_ARG), .CFG_ARG(CFG_ARG),
    .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY(BYTE_READY), .PKT_STATUS(PKT_STATUS), .PKT_DX(PKT_DX), .PKT_DY(PKT_DY),
    .PKT_VALID(PKT_VALID)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic rx(input logic [7:0] b, input logic [1:0] ec);
    BYTE_READ = b;
    BYTE_ERROR_CODE = ec;
    BYTE_READY = 1'b1;
    tick;
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = '0;
  endtask
  task automatic pkt(input string tag, input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
    chk({tag, " valid"}, PKT_VALID, 1);
    chk({tag, " status"}, PKT_STATUS, s);
    chk({tag, " dx"}, PKT_DX, x);
    chk({tag, " dy"}, PKT_DY, y);
  endtask
  task automatic start_cfg(input string tag, input logic [7:0] c, input logic h, input logic [7:0] a);
    CFG_CMD = c;
    CFG_HAS_ARG = h;
    CFG_ARG = a;
    CFG_REQ = 1'b1;
    tick;
    chk({tag, " busy rise"}, CFG_BUSY, 1);
    CFG_REQ = 1'b0;
  endtask
  task automatic serve(input string tag, input logic [7:0] exp, input int njunk, input bit do_ack, input logic [7:0] ackb);
    int n = 0;
    while (!SEND_BYTE && n < 200) begin
      tick;
      n++;
    end
    chk({tag, " send"}, SEND_BYTE, 1);
    chk({tag, " byte"}, BYTE_TO_SEND, exp);
    chk({tag, " rd_en off"}, READ_ENABLE, 0);
    chk({tag, " busy"}, CFG_BUSY, 1);
    tick;
    chk({tag, " one-shot"}, SEND_BYTE, 0);
    tick;
    BYTE_SENT = 1'b1;
    tick;
    BYTE_SENT = 1'b0;
    for (int i = 0; i < njunk; i++) rx(8'h18 + 8'(i), 2'd0);
    if (do_ack) rx(ackb, 2'd0);
  endtask
  initial begin
    tick;
    tick;
    chk("rst own", OWN, 0);
    chk("rst busy", CFG_BUSY, 0);
    chk("rst send", SEND_BYTE, 0);
    chk("rst rd_en", READ_ENABLE, 0);
    chk("rst pkt", {PKT_VALID, PKT_STATUS, PKT_DX, PKT_DY}, 0);
    RESET = 1'b0;
    STREAM_EN = 1'b1;
    tick;
    chk("own", OWN, 1);
    chk("rd_en", READ_ENABLE, 1);
    rx(8'h08, 0);
    rx(8'h05, 0);
    chk("no early valid", PKT_VALID, 0);
    rx(8'hFB, 0);
    pkt("pkt1", 8'h08, 8'h05, 8'hFB);
    tick;
    chk("pkt1 pulse", PKT_VALID, 0);
    rx(8'h00, 0);
    rx(8'h08, 0);
    rx(8'h01, 0);
    rx(8'h02, 0);
    pkt("pkt2", 8'h08, 8'h01, 8'h02);
    rx(8'h08, 0);
    rx(8'h09, 2'd1);
    rx(8'h0A, 0);
    rx(8'h0B, 0);
    chk("err drop", PKT_VALID, 0);
    rx(8'h0C, 0);
    pkt("pkt3", 8'h0A, 8'h0B, 8'h0C);
    start_cfg("c3", 8'hF3, 1'b1, 8'h28);
    serve("c3 dis", 8'hF5, 0, 1, 8'hFA);
    serve("c3 cmd", 8'hF3, 0, 1, 8'hFA);
    serve("c3 arg", 8'h28, 0, 1, 8'hFA);
    serve("c3 en", 8'hF4, 0, 1, 8'hFA);
    chk("c3 done", CFG_DONE, 1);
    chk("c3 err", CFG_ERR, 0);
    chk("c3 busy", CFG_BUSY, 0);
    tick;
    chk("c3 done pulse", CFG_DONE, 0);
    rx(8'h18, 0);
    rx(8'h11, 0);
    rx(8'h22, 0);
    pkt("c3 resume", 8'h18, 8'h11, 8'h22);
    rx(8'h08, 0);
    CFG_CMD = 8'hE6;
    CFG_HAS_ARG = 1'b0;
    CFG_REQ = 1'b1;
    tick;
    tick;
    chk("c4 held busy", CFG_BUSY, 0);
    chk("c4 held send", SEND_BYTE, 0);
    rx(8'h03, 0);
    rx(8'h04, 0);
    pkt("c4 pkt", 8'h08, 8'h03, 8'h04);
    chk("c4 no send yet", SEND_BYTE, 0);
    tick;
    chk("c4 busy rise", CFG_BUSY, 1);
    CFG_REQ = 1'b0;
    serve("c4 dis", 8'hF5, 2, 1, 8'hFA);
    serve("c4 cmd", 8'hE6, 0, 1, 8'hFA);
    serve("c4 en", 8'hF4, 0, 1, 8'hFA);
    chk("c4 done", CFG_DONE, 1);
    chk("c4 err", CFG_ERR, 0);
    tick;
    start_cfg("c5", 8'hE8, 1'b1, 8'h02);
    serve("c5 dis", 8'hF5, 0, 1, 8'hFA);
    serve("c5 cmd", 8'hE8, 0, 1, 8'hFE);
    serve("c5 en", 8'hF4, 0, 1, 8'hFA);
    chk("c5 err", CFG_ERR, 1);
    chk("c5 done", CFG_DONE, 0);
    tick;
    chk("c5 err pulse", CFG_ERR, 0);
    start_cfg("c6", 8'hF3, 1'b1, 8'h64);
    serve("c6 dis", 8'hF5, 0, 0, 8'h00);
    serve("c6 en", 8'hF4, 0, 1, 8'hFA);
    chk("c6 err", CFG_ERR, 1);
    chk("c6 done", CFG_DONE, 0);
    tick;
    start_cfg("c7", 8'hE8, 1'b0, 8'h00);
    chk("c7 send", SEND_BYTE, 1);
    tick;
    STREAM_EN = 1'b0;
    tick;
    chk("c7 err", CFG_ERR, 1);
    chk("c7 own", OWN, 0);
    chk("c7 busy", CFG_BUSY, 0);
    chk("c7 done", CFG_DONE, 0);
    tick;
    chk("c7 err pulse", CFG_ERR, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
